// File: rtl/mips32_rtype_multicycle_if.sv
// Instruction handshake, preload port and retire strobe of the multi-cycle R-type core.
// The master drives instructions and preloads; the slave (the core) reports retirements.
interface mips32_rtype_multicycle_if #(
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic              pl_we;
  logic [4:0]        pl_addr;
  logic [DATA_W-1:0] pl_data;
  logic              result_valid;
  logic [DATA_W-1:0] result;
  logic [4:0]        result_rd;
  logic              ovf;
  logic              illegal;

  modport master (
    output instr_valid, instr, pl_we, pl_addr, pl_data,
    input  instr_ready, result_valid, result, result_rd, ovf, illegal
  );

  modport slave (
    input  instr_valid, instr, pl_we, pl_addr, pl_data,
    output instr_ready, result_valid, result, result_rd, ovf, illegal
  );
endinterface

// File: rtl/mips32_rtype_multicycle.sv
// Multi-cycle MIPS R-type core: IDLE -> DECODE -> EXEC -> WB over a 32-entry register file,
// with a one-cycle retire strobe carrying result, destination, overflow and illegal flags.
module mips32_rtype_multicycle #(
  parameter int DATA_W      = 32,
  parameter bit TRAP_ON_OVF = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  mips32_rtype_multicycle_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t            state_q, state_d;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] a_q, b_q, alu_q, alu_d, result_q;
  logic              ovf_q, ovf_d, ill_q, ill_d, funct_ok;
  logic              result_valid_q, res_ovf_q, res_ill_q;
  logic [4:0]        result_rd_q;
  logic              accept, pl_take, wb_en;

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [SH_W-1:0]   sh_imm, sh_var;
  logic [DATA_W-1:0] sum, diff;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign sh_imm = SH_W'(shamt);
  assign sh_var = a_q[SH_W-1:0];
  assign sum    = a_q + b_q;
  assign diff   = a_q - b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
      6'h26, 6'h27, 6'h2A, 6'h2B: funct_ok = 1'b1;
      default:                    funct_ok = 1'b0;
    endcase
    ill_d = (op != 6'd0) || !funct_ok;
  end

  always_comb begin
    alu_d = '0;
    ovf_d = 1'b0;
    case (funct)
      6'h24: alu_d = a_q & b_q;
      6'h25: alu_d = a_q | b_q;
      6'h26: alu_d = a_q ^ b_q;
      6'h27: alu_d = ~(a_q | b_q);
      6'h20: begin
        alu_d = sum;
        ovf_d = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      6'h21: alu_d = sum;
      6'h22: begin
        alu_d = diff;
        ovf_d = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      6'h23: alu_d = diff;
      6'h2A: alu_d = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      6'h2B: alu_d = {{(DATA_W-1){1'b0}}, a_q < b_q};
      6'h00: alu_d = b_q << sh_imm;
      6'h02: alu_d = b_q >> sh_imm;
      6'h03: alu_d = $signed(b_q) >>> sh_imm;
      6'h04: alu_d = b_q << sh_var;
      6'h06: alu_d = b_q >> sh_var;
      6'h07: alu_d = $signed(b_q) >>> sh_var;
      default: alu_d = '0;
    endcase
  end

  // A preload loses to an instruction accepted on the same edge.
  assign pl_take = (state_q == S_IDLE) && !accept && bus.pl_we && (bus.pl_addr != 5'd0);
  assign wb_en   = (state_q == S_WB) && (rd != 5'd0) && !ill_q && !(ovf_q && TRAP_ON_OVF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[rd] <= alu_q;
    end else if (pl_take) begin
      regs_q[bus.pl_addr] <= bus.pl_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      alu_q          <= '0;
      ovf_q          <= 1'b0;
      ill_q          <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_rd_q    <= '0;
      res_ovf_q      <= 1'b0;
      res_ill_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) ir_q <= bus.instr;
        end
        S_DECODE: begin
          a_q   <= regs_q[rs];
          b_q   <= regs_q[rt];
          ill_q <= ill_d;
        end
        S_EXEC: begin
          alu_q <= alu_d;
          ovf_q <= ovf_d && !ill_q;
        end
        S_WB: begin
          result_valid_q <= 1'b1;
          result_q       <= ill_q ? '0 : alu_q;
          result_rd_q    <= rd;
          res_ovf_q      <= ovf_q;
          res_ill_q      <= ill_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_ready  = (state_q == S_IDLE);
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.result_rd    = result_rd_q;
  assign bus.ovf          = res_ovf_q;
  assign bus.illegal      = res_ill_q;
endmodule

// File: tb/tb_mips32_rtype_multicycle.sv
// Directed bench for the multi-cycle R-type core: latency, ALU ops, overflow trap,
// illegal decode, R0, preload rules, back-to-back handshake and mid-flight reset.
module tb_mips32_rtype_multicycle;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  mips32_rtype_multicycle_if #(.DATA_W(32)) bus ();

  mips32_rtype_multicycle #(.DATA_W(32), .TRAP_ON_OVF(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] exp;
    logic [4:0]  rd;
    logic        ovf;
  } vec_t;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.pl_we = 1'b1; bus.pl_addr = a; bus.pl_data = d;
    @(negedge clk);
    bus.pl_we = 1'b0;
  endtask

  // Issues one instruction; lat counts edges from acceptance to the observed strobe.
  task automatic issue(input logic [31:0] w, output logic [31:0] res, output logic [4:0] rd,
                       output logic o, output logic il, output int lat);
    int n;
    @(negedge clk);
    bus.instr = w; bus.instr_valid = 1'b1;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.result_valid) break;
    end
    res = bus.result; rd = bus.result_rd; o = bus.ovf; il = bus.illegal;
  endtask

  task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
    logic [4:0] rd; logic o, il; int lat;
    issue(rtype(idx, 5'd0, 5'd0, 5'd0, 6'h25), val, rd, o, il, lat);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.pl_we = 1'b0; bus.pl_addr = '0; bus.pl_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
    checks++;
    if ({bus.result_valid, bus.result, bus.result_rd, bus.ovf, bus.illegal} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b r=%h rd=%0d o=%b il=%b exp all zero",
               bus.result_valid, bus.result, bus.result_rd, bus.ovf, bus.illegal);
    end
    read_reg(5'd2, v);
    checks++;
    if (v !== 32'h0) begin failures++; $display("FAIL reset_r2 got=%h exp=00000000", v); end
  endtask

  task automatic test_basic;
    logic [31:0] res; logic [4:0] rd; logic o, il; int lat;
    preload(5'd2, 32'h0000000F);
    preload(5'd3, 32'h000000F0);
    issue(32'h00435024, res, rd, o, il, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL and_latency got=%0d exp=3", lat); end
    checks++;
    if (res !== 32'h0 || rd !== 5'd10 || o !== 1'b0 || il !== 1'b0) begin
      failures++; $display("FAIL and_result got=%h rd=%0d o=%b il=%b exp=00000000 rd=10 o=0 il=0", res, rd, o, il);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL strobe_width got=%b exp=0", bus.result_valid); end
    issue(32'h00436025, res, rd, o, il, lat);
    checks++;
    if (res !== 32'h000000FF || rd !== 5'd12) begin
      failures++; $display("FAIL or_result got=%h rd=%0d exp=000000ff rd=12", res, rd);
    end
    read_reg(5'd12, res);
    checks++;
    if (res !== 32'h000000FF) begin failures++; $display("FAIL or_writeback got=%h exp=000000ff", res); end
  endtask

  task automatic test_overflow;
    logic [31:0] res; logic [4:0] rd; logic o, il; int lat;
    preload(5'd4, 32'h7FFFFFFF);
    preload(5'd5, 32'h00000001);
    issue(32'h00856820, res, rd, o, il, lat);
    checks++;
    if (res !== 32'h80000000 || o !== 1'b1) begin failures++; $display("FAIL add_ovf got=%h o=%b exp=80000000 o=1", res, o); end
    read_reg(5'd13, res);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL add_trap_r13 got=%h exp=00000000", res); end
    issue(32'h00857021, res, rd, o, il, lat);
    checks++;
    if (res !== 32'h80000000 || o !== 1'b0) begin failures++; $display("FAIL addu got=%h o=%b exp=80000000 o=0", res, o); end
    read_reg(5'd14, res);
    checks++;
    if (res !== 32'h80000000) begin failures++; $display("FAIL addu_r14 got=%h exp=80000000", res); end
    issue(rtype(5'd14, 5'd5, 5'd15, 5'd0, 6'h22), res, rd, o, il, lat);
    checks++;
    if (res !== 32'h7FFFFFFF || o !== 1'b1) begin failures++; $display("FAIL sub_ovf got=%h o=%b exp=7fffffff o=1", res, o); end
    read_reg(5'd15, res);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL sub_trap_r15 got=%h exp=00000000", res); end
  endtask

  task automatic test_alu_ops;
    vec_t v [11];
    logic [31:0] res; logic [4:0] rd; logic o, il; int lat;
    preload(5'd7, 32'h80000000);
    v[0]  = '{"nor",  rtype(5'd2,  5'd3, 5'd20, 5'd0,  6'h27), 32'hFFFFFF00, 5'd20, 1'b0};
    v[1]  = '{"sub",  rtype(5'd2,  5'd3, 5'd21, 5'd0,  6'h22), 32'hFFFFFF1F, 5'd21, 1'b0};
    v[2]  = '{"slt",  rtype(5'd21, 5'd2, 5'd22, 5'd0,  6'h2A), 32'h00000001, 5'd22, 1'b0};
    v[3]  = '{"sltu", rtype(5'd21, 5'd2, 5'd23, 5'd0,  6'h2B), 32'h00000000, 5'd23, 1'b0};
    v[4]  = '{"sra",  32'h00079103,                            32'hF8000000, 5'd18, 1'b0};
    v[5]  = '{"srl",  rtype(5'd0,  5'd7, 5'd19, 5'd4,  6'h02), 32'h08000000, 5'd19, 1'b0};
    v[6]  = '{"sllv", rtype(5'd2,  5'd3, 5'd24, 5'd0,  6'h04), 32'h00780000, 5'd24, 1'b0};
    v[7]  = '{"srav", rtype(5'd5,  5'd7, 5'd25, 5'd0,  6'h07), 32'hC0000000, 5'd25, 1'b0};
    v[8]  = '{"sll31",rtype(5'd0,  5'd5, 5'd26, 5'd31, 6'h00), 32'h80000000, 5'd26, 1'b0};
    v[9]  = '{"srlv", rtype(5'd2,  5'd7, 5'd17, 5'd0,  6'h06), 32'h00010000, 5'd17, 1'b0};
    v[10] = '{"subu", rtype(5'd14, 5'd5, 5'd27, 5'd0,  6'h23), 32'h7FFFFFFF, 5'd27, 1'b0};
    for (int i = 0; i < 11; i++) begin
      issue(v[i].instr, res, rd, o, il, lat);
      checks++;
      if (res !== v[i].exp || rd !== v[i].rd || o !== v[i].ovf || il !== 1'b0) begin
        failures++;
        $display("FAIL op_%s got=%h rd=%0d o=%b il=%b exp=%h rd=%0d o=%b il=0",
                 v[i].name, res, rd, o, il, v[i].exp, v[i].rd, v[i].ovf);
      end
    end
    read_reg(5'd18, res);
    checks++;
    if (res !== 32'hF8000000) begin failures++; $display("FAIL sra_r18 got=%h exp=f8000000", res); end
  endtask

  task automatic test_illegal_r0;
    logic [31:0] res; logic [4:0] rd; logic o, il; int lat;
    preload(5'd9, 32'h12345678);
    issue(32'h8C000000, res, rd, o, il, lat);
    checks++;
    if (il !== 1'b1 || res !== 32'h0 || o !== 1'b0) begin
      failures++; $display("FAIL illegal_op got il=%b r=%h o=%b exp il=1 r=0 o=0", il, res, o);
    end
    issue(rtype(5'd2, 5'd3, 5'd9, 5'd0, 6'h01), res, rd, o, il, lat);
    checks++;
    if (il !== 1'b1 || res !== 32'h0 || rd !== 5'd9) begin
      failures++; $display("FAIL illegal_funct got il=%b r=%h rd=%0d exp il=1 r=0 rd=9", il, res, rd);
    end
    issue({6'h08, 5'd2, 5'd3, 5'd9, 5'd0, 6'h20}, res, rd, o, il, lat);
    checks++;
    if (il !== 1'b1 || res !== 32'h0) begin failures++; $display("FAIL illegal_opfunct got il=%b r=%h exp il=1 r=0", il, res); end
    read_reg(5'd9, res);
    checks++;
    if (res !== 32'h12345678) begin failures++; $display("FAIL illegal_r9 got=%h exp=12345678", res); end
    issue(rtype(5'd2, 5'd3, 5'd0, 5'd0, 6'h25), res, rd, o, il, lat);
    checks++;
    if (lat !== 3 || res !== 32'h000000FF || rd !== 5'd0 || il !== 1'b0) begin
      failures++; $display("FAIL r0_strobe got lat=%0d r=%h rd=%0d il=%b exp lat=3 r=000000ff rd=0 il=0", lat, res, rd, il);
    end
    read_reg(5'd0, res);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL r0_zero got=%h exp=00000000", res); end
  endtask

  task automatic test_preload_rules;
    logic [31:0] res;
    @(negedge clk);
    bus.instr = rtype(5'd2, 5'd3, 5'd11, 5'd0, 6'h21); bus.instr_valid = 1'b1;
    @(posedge clk); #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    bus.pl_we = 1'b1; bus.pl_addr = 5'd28; bus.pl_data = 32'h0000DEAD;
    @(negedge clk);
    bus.pl_we = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    bus.instr = rtype(5'd2, 5'd3, 5'd12, 5'd0, 6'h26); bus.instr_valid = 1'b1;
    bus.pl_we = 1'b1; bus.pl_addr = 5'd29; bus.pl_data = 32'h0000BEEF;
    @(posedge clk); #1 bus.instr_valid = 1'b0; bus.pl_we = 1'b0;
    repeat (4) @(negedge clk);
    read_reg(5'd28, res);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL preload_busy got=%h exp=00000000", res); end
    read_reg(5'd11, res);
    checks++;
    if (res !== 32'h000000FF) begin failures++; $display("FAIL busy_instr_r11 got=%h exp=000000ff", res); end
    read_reg(5'd29, res);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL preload_vs_accept got=%h exp=00000000", res); end
    read_reg(5'd12, res);
    checks++;
    if (res !== 32'h000000FF) begin failures++; $display("FAIL accept_wins_r12 got=%h exp=000000ff", res); end
    preload(5'd30, 32'hCAFEF00D);
    preload(5'd0, 32'h0000FFFF);
    read_reg(5'd30, res);
    checks++;
    if (res !== 32'hCAFEF00D) begin failures++; $display("FAIL preload_r30 got=%h exp=cafef00d", res); end
    read_reg(5'd0, res);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL preload_r0 got=%h exp=00000000", res); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prog [3];
    logic [31:0] exp_res [3];
    int acc[$];
    logic [31:0] res[$];
    int n;
    prog[0] = rtype(5'd2, 5'd3, 5'd1, 5'd0, 6'h20);
    prog[1] = rtype(5'd1, 5'd1, 5'd4, 5'd0, 6'h20);
    prog[2] = rtype(5'd4, 5'd1, 5'd6, 5'd0, 6'h20);
    exp_res[0] = 32'd12; exp_res[1] = 32'd24; exp_res[2] = 32'd36;
    preload(5'd2, 32'd5);
    preload(5'd3, 32'd7);
    @(negedge clk);
    bus.instr = prog[0]; bus.instr_valid = 1'b1;
    n = 0;
    for (int t = 0; t < 24; t++) begin
      if (bus.result_valid) res.push_back(bus.result);
      if (bus.instr_valid && bus.instr_ready) begin
        acc.push_back(t);
        n++;
      end
      @(negedge clk);
      if (n < 3) bus.instr = prog[n];
      else       bus.instr_valid = 1'b0;
    end
    bus.instr_valid = 1'b0;
    checks++;
    if (acc.size() != 3) begin
      failures++; $display("FAIL b2b_accepts got=%0d exp=3", acc.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
        failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=4,4", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    checks++;
    if (res.size() != 3) begin
      failures++; $display("FAIL b2b_strobes got=%0d exp=3", res.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (res[i] !== exp_res[i]) begin
          failures++; $display("FAIL b2b_result%0d got=%h exp=%h", i, res[i], exp_res[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    int strobes;
    @(negedge clk);
    bus.instr = rtype(5'd2, 5'd3, 5'd16, 5'd0, 6'h20); bus.instr_valid = 1'b1;
    @(posedge clk); #1 bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.result_valid, bus.result, bus.result_rd, bus.ovf, bus.illegal} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got v=%b r=%h rd=%0d o=%b il=%b exp all zero",
               bus.result_valid, bus.result, bus.result_rd, bus.ovf, bus.illegal);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", bus.instr_ready); end
    strobes = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.result_valid) strobes++;
    end
    checks++;
    if (strobes != 0) begin failures++; $display("FAIL midreset_strobe got=%0d exp=0", strobes); end
    read_reg(5'd16, res);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL midreset_r16 got=%h exp=00000000", res); end
    read_reg(5'd2, res);
    checks++;
    if (res !== 32'h0) begin failures++; $display("FAIL midreset_r2 got=%h exp=00000000", res); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_alu_ops();
    test_illegal_r0();
    test_preload_rules();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
